altr_hps_gtie_bank: RTL
=======================

// Module: altr_hps_gtie_bank
// PURPOSE
//  Parametrised bank of run-time programmable tie-off cells; next generation of the single
//  fixed tie-high cell. Drives WIDTH constant-level outputs (straps, mode pins, macro tie-offs)
//  that power up at DEFAULT and can be reprogrammed through a masked valid/ready write,
//  committed glitch-free after a settle delay, then frozen with a sticky lock.
// PARAMETERS
//  WIDTH       8          number of tie-off outputs (1..64)
//  DEFAULT     {WIDTH{1'b1}}  reset value of z_out and staging register (all-high, as a GTIEH)
//  SETTLE_CYC  4          cycles between commit acceptance and z_out update (1..255)
// PORTS
//  clk         in   1      clock
//  rst         in   1      synchronous reset, active-high
//  cfg_valid   in   1      write request
//  cfg_ready   out  1      write accepted when cfg_valid & cfg_ready
//  cfg_data    in   WIDTH  new tie values
//  cfg_mask    in   WIDTH  per-bit write enable (1 = update bit)
//  commit      in   1      single-cycle pulse: apply staged value to z_out
//  lock_req    in   1      single-cycle pulse: freeze bank until reset
//  z_out       out  WIDTH  tie-off outputs (registered)
//  dirty       out  1      staged != z_out
//  busy        out  1      settle in progress
//  done        out  1      one-cycle pulse on the cycle z_out takes the staged value
//  locked      out  1      sticky lock status
// BEHAVIOUR
//  Reset (rst=1 at posedge): z_out=DEFAULT, staged=DEFAULT, state=IDLE, cnt=0, locked=0,
//   done=0, busy=0; cfg_ready=1 on the first cycle after reset. Reset mid-settle aborts commit.
//  cfg_ready = (state==IDLE) & ~locked (combinational from registers only).
//  Write: on accept, staged <= (staged & ~cfg_mask) | (cfg_data & cfg_mask); z_out unchanged.
//   cfg_mask==0 accepted as a no-op. Writes while not ready are ignored (no buffering).
//  States: IDLE -> SETTLE on commit & ~locked; cnt loads SETTLE_CYC-1.
//   SETTLE: cnt decrements each cycle; at cnt==0: z_out <= staged, done=1, -> IDLE.
//   Latency: commit at cycle T -> z_out and done change at posedge T+SETTLE_CYC.
//  commit while in SETTLE or while locked: ignored. commit with dirty=0: still runs the
//   settle sequence and pulses done (z_out unchanged).
//  Same cycle cfg_valid&cfg_ready and commit in IDLE: write lands first; commit applies the
//   newly written value.
//  lock_req: locked<=1 in IDLE (same cycle as a write/commit: write/commit take effect, then
//   lock). In SETTLE: lock pending; locked<=1 on the done cycle, the commit completes.
//   Once locked only rst clears it; z_out holds.
//  busy = (state==SETTLE). dirty registered-compare, updates the cycle after staged/z_out.
//  z_out is driven only from a flop; never changes except on the done cycle or reset.
// STRUCTURE
//  Package altr_hps_gtie_pkg: state encoding (ST_IDLE=1'b0, ST_SETTLE=1'b1), CNT_W =
//   $clog2(SETTLE_CYC+1) helper, WIDTH/SETTLE_CYC legality checks.
//  Sub-module altr_hps_gtie_settle_cnt: loadable down-counter with zero flag (load, dec, zero).
//  Top holds staged/z_out/locked registers, FSM and lock-pending flag.
// TESTING (WIDTH=8, DEFAULT=8'hFF, SETTLE_CYC=4)
//  Reset -> z_out=8'hFF, locked=0, busy=0, cfg_ready=1, dirty=0.
//  Write data=8'h00 mask=8'h0F, commit at T -> dirty=1, z_out=8'hFF until T+4, then 8'hF0,
//   done pulse exactly at T+4, busy high T+1..T+4.
//  Write during SETTLE -> cfg_ready=0, write dropped; second commit during SETTLE ignored.
//  Write and commit same cycle (data=8'hA5 mask=8'hFF) -> z_out=8'hA5 after 4 cycles.
//  lock_req during SETTLE -> commit completes, locked=1 on done cycle; later writes/commits
//   ignored, cfg_ready=0; rst -> z_out=8'hFF, locked=0.
//  rst asserted mid-SETTLE -> z_out stays 8'hFF, no done pulse, staged=8'hFF.

Source files
------------

// File: rtl/altr_hps_gtie_pkg.sv
// Shared definitions for the programmable tie-off bank: FSM encoding,
// counter sizing and parameter legality helpers.
package altr_hps_gtie_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SETTLE = 1'b1
  } gtie_state_e;

  function automatic int cnt_w(input int settle_cyc);
    return $clog2(settle_cyc + 1);
  endfunction

  function automatic bit params_ok(input int width, input int settle_cyc);
    return (width >= 1) && (width <= 64) && (settle_cyc >= 1) && (settle_cyc <= 255);
  endfunction

endpackage

// File: rtl/altr_hps_gtie_settle_cnt.sv
// Loadable down-counter with a zero flag, used to time the commit settle window.
module altr_hps_gtie_settle_cnt #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/altr_hps_gtie_bank.sv
// Bank of run-time programmable tie-off outputs: masked staging writes,
// delayed glitch-free commit to the output flops, and a sticky lock.
module altr_hps_gtie_bank
  import altr_hps_gtie_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] DEFAULT    = {WIDTH{1'b1}},
  parameter int               SETTLE_CYC = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_data,
  input  logic [WIDTH-1:0] cfg_mask,
  input  logic             commit,
  input  logic             lock_req,
  output logic [WIDTH-1:0] z_out,
  output logic             dirty,
  output logic             busy,
  output logic             done,
  output logic             locked
);

  localparam int               CNT_W    = cnt_w(SETTLE_CYC);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYC - 1);

  if (!params_ok(WIDTH, SETTLE_CYC)) begin : g_bad_params
    $error("altr_hps_gtie_bank: WIDTH must be 1..64 and SETTLE_CYC 1..255");
  end

  gtie_state_e      state_q, state_d;
  logic [WIDTH-1:0] staged_q, staged_d;
  logic [WIDTH-1:0] z_q, z_d;
  logic             locked_q, locked_d;
  logic             lock_pend_q, lock_pend_d;
  logic             dirty_q, done_q;
  logic             accept_s, start_s, finish_s, in_idle_s;
  logic             cnt_zero_s;
  logic [CNT_W-1:0] cnt_s;

  assign in_idle_s = (state_q == ST_IDLE);
  assign cfg_ready = in_idle_s & ~locked_q;
  assign accept_s  = cfg_valid & cfg_ready;
  assign start_s   = commit & in_idle_s & ~locked_q;
  assign finish_s  = (state_q == ST_SETTLE) & cnt_zero_s;

  altr_hps_gtie_settle_cnt #(.CNT_W(CNT_W)) u_settle_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (start_s),
    .load_val (CNT_LOAD),
    .dec      ((state_q == ST_SETTLE) & ~cnt_zero_s),
    .cnt      (cnt_s),
    .zero     (cnt_zero_s)
  );

  // A lock request seen mid-settle is deferred so the running commit still lands.
  always_comb begin
    staged_d    = accept_s ? ((staged_q & ~cfg_mask) | (cfg_data & cfg_mask)) : staged_q;
    z_d         = finish_s ? staged_q : z_q;
    state_d     = state_q;
    locked_d    = locked_q;
    lock_pend_d = lock_pend_q;
    case (state_q)
      ST_IDLE: begin
        state_d  = start_s ? ST_SETTLE : ST_IDLE;
        locked_d = locked_q | lock_req;
      end
      ST_SETTLE: begin
        if (finish_s) begin
          state_d     = ST_IDLE;
          locked_d    = locked_q | lock_pend_q | lock_req;
          lock_pend_d = 1'b0;
        end else begin
          state_d     = ST_SETTLE;
          lock_pend_d = lock_pend_q | lock_req;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      staged_q    <= DEFAULT;
      z_q         <= DEFAULT;
      locked_q    <= 1'b0;
      lock_pend_q <= 1'b0;
      dirty_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      staged_q    <= staged_d;
      z_q         <= z_d;
      locked_q    <= locked_d;
      lock_pend_q <= lock_pend_d;
      dirty_q     <= (staged_q != z_q);
      done_q      <= finish_s;
    end
  end

  assign z_out  = z_q;
  assign dirty  = dirty_q;
  assign busy   = (state_q == ST_SETTLE);
  assign done   = done_q;
  assign locked = locked_q;

endmodule
